// File: rtl/regfile_param.sv
// Parametrised multi-read-port register file with optional zero register and a sequential clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    sa,
  output logic [NREAD*WIDTH-1:0] a,
  input  logic [WIDTH-1:0]       d,
  input  logic [AW-1:0]          da,
  input  logic                   w,
  input  logic                   clr_req,
  output logic                   busy,
  output logic                   wr_drop,
  input  logic [AW-1:0]          dbg_sel,
  output logic [15:0]            dbg_out
);

  localparam logic [AW-1:0] ZADDR = AW'(DEPTH - 1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    w_cnt_nxt;
  logic             r_busy;
  logic             r_wr_drop;
  logic             w_wr_drop_nxt;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_data;
  logic             w_zero_hit;

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign w_zero_hit = (ZERO_REG != 0) && (da == ZADDR);

  // Control and sweep registers; the sweep itself is the only storage reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_CLEAR;
      r_cnt     <= '0;
      r_wr_drop <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr_drop <= w_wr_drop_nxt;
      r_busy    <= (w_state_nxt == S_CLEAR);
    end
  end

  // Next state, sweep counter and the single storage write port.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wr_drop_nxt = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_addr    = da;
    w_mem_data    = d;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nxt   = S_CLEAR;
          w_cnt_nxt     = '0;
          w_wr_drop_nxt = w;
        end else if (w && !w_zero_hit) begin
          w_mem_we = 1'b1;
        end
      end
      S_CLEAR: begin
        w_mem_we      = 1'b1;
        w_mem_addr    = r_cnt;
        w_mem_data    = '0;
        w_cnt_nxt     = r_cnt + AW'(1);
        w_wr_drop_nxt = w;
        if (r_cnt == ZADDR) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
    if (!reset) w_mem_we = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  // Combinational read ports; priority: busy, zero register, forwarding, storage.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    w_sa;
    logic [WIDTH-1:0] w_rd;
    assign w_sa = sa[k*AW +: AW];
    always_comb begin
      w_rd = r_mem[w_sa];
`ifdef REGFILE_BYPASS_EN
      if (w && (w_sa == da)) w_rd = d;
`endif
      if ((ZERO_REG != 0) && (w_sa == ZADDR)) w_rd = '0;
      if (r_busy) w_rd = '0;
    end
    assign a[k*WIDTH +: WIDTH] = w_rd;
  end

  assign busy    = r_busy;
  assign wr_drop = r_wr_drop;
  assign dbg_out = r_busy ? 16'h0000 : 16'(r_mem[dbg_sel]);

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default config, ZERO_REG=0 twin and a small 4-port 16x8 instance.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Shared stimulus for the default instance and its ZERO_REG=0 twin
  logic          reset;
  logic [9:0]    sa;
  logic [63:0]   d;
  logic [4:0]    da;
  logic          w;
  logic          clr_req;
  logic [4:0]    dbg_sel;
  logic [127:0]  a_z, a_n;
  logic          busy_z, busy_n, wr_drop_z, wr_drop_n;
  logic [15:0]   dbg_z, dbg_n;

  // Small instance: NREAD=4, WIDTH=16, DEPTH=8
  logic [11:0]   s_sa;
  logic [63:0]   s_a;
  logic [15:0]   s_d;
  logic [2:0]    s_da;
  logic          s_w;
  logic          s_clr;
  logic          s_busy, s_wr_drop;
  logic [2:0]    s_dbg_sel;
  logic [15:0]   s_dbg;

  regfile_param u_dut (
    .clock(clock), .reset(reset), .sa(sa), .a(a_z), .d(d), .da(da), .w(w),
    .clr_req(clr_req), .busy(busy_z), .wr_drop(wr_drop_z), .dbg_sel(dbg_sel), .dbg_out(dbg_z)
  );

  regfile_param #(.ZERO_REG(0)) u_nz (
    .clock(clock), .reset(reset), .sa(sa), .a(a_n), .d(d), .da(da), .w(w),
    .clr_req(clr_req), .busy(busy_n), .wr_drop(wr_drop_n), .dbg_sel(dbg_sel), .dbg_out(dbg_n)
  );

  regfile_param #(.WIDTH(16), .DEPTH(8), .NREAD(4), .ZERO_REG(1)) u_small (
    .clock(clock), .reset(reset), .sa(s_sa), .a(s_a), .d(s_d), .da(s_da), .w(s_w),
    .clr_req(s_clr), .busy(s_busy), .wr_drop(s_wr_drop), .dbg_sel(s_dbg_sel), .dbg_out(s_dbg)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    int n;
    int bad;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++; if (busy_z !== 1'b1) begin errors++; $display("FAIL reset_busy got %b expected 1", busy_z); end
    checks++; if (wr_drop_z !== 1'b0) begin errors++; $display("FAIL reset_wr_drop got %b expected 0", wr_drop_z); end
    checks++; if (dbg_z !== 16'h0) begin errors++; $display("FAIL reset_dbg got %h expected 0000", dbg_z); end
    n = 0;
    bad = 0;
    while (busy_z && n < 100) begin
      sa = {5'(n), 5'(n + 7)};
      #1;
      if (a_z !== 128'h0 || a_n !== 128'h0) bad++;
      n++;
      tick();
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL reset_busy_cycles got %0d expected 32", n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reads_while_busy got %0d nonzero expected 0", bad); end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      sa = {5'(i), 5'(31 - i)};
      #1;
      if (a_z !== 128'h0 || a_n !== 128'h0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL swept_regs got %0d nonzero expected 0", bad); end
  endtask

  task automatic test_write_forward();
    logic [63:0]  v;
    logic [127:0] exp_a;
    v = 64'hDEAD_BEEF_0123_4567;
    sa = {5'd5, 5'd5};
    d = v;
    da = 5'd5;
    w = 1'b1;
    dbg_sel = 5'd5;
    #1;
    exp_a = BYP ? {v, v} : 128'h0;
    checks++; if (a_z !== exp_a) begin errors++; $display("FAIL fwd_write_cycle got %h expected %h", a_z, exp_a); end
    checks++; if (dbg_z !== 16'h0) begin errors++; $display("FAIL dbg_unforwarded got %h expected 0000", dbg_z); end
    tick();
    w = 1'b0;
    #1;
    checks++; if (a_z !== {v, v}) begin errors++; $display("FAIL write_next_cycle got %h expected %h", a_z, {v, v}); end
    checks++; if (dbg_z !== 16'h4567) begin errors++; $display("FAIL dbg_after_write got %h expected 4567", dbg_z); end
  endtask

  task automatic test_zero_reg();
    logic [63:0]  ones;
    logic [127:0] exp_n;
    ones = '1;
    d = ones;
    da = 5'd31;
    w = 1'b1;
    sa = {5'd31, 5'd31};
    #1;
    exp_n = BYP ? {ones, ones} : 128'h0;
    checks++; if (a_z !== 128'h0) begin errors++; $display("FAIL zero_reg_write_cycle got %h expected 0", a_z); end
    checks++; if (a_n !== exp_n) begin errors++; $display("FAIL nozero_write_cycle got %h expected %h", a_n, exp_n); end
    tick();
    w = 1'b0;
    #1;
    checks++; if (a_z !== 128'h0) begin errors++; $display("FAIL zero_reg_read got %h expected 0", a_z); end
    checks++; if (wr_drop_z !== 1'b0) begin errors++; $display("FAIL zero_reg_wr_drop got %b expected 0", wr_drop_z); end
    checks++; if (a_n !== {ones, ones}) begin errors++; $display("FAIL nozero_read got %h expected %h", a_n, {ones, ones}); end
  endtask

  task automatic test_clear_collision();
    int n;
    int bad;
    logic [7:0] drop_trace;
    for (int i = 0; i < 8; i++) begin
      da = 5'(i);
      d = 64'(i * 3);
      w = 1'b1;
      tick();
    end
    w = 1'b0;
    sa = {5'd7, 5'd2};
    #1;
    checks++; if (a_z !== {64'd21, 64'd6}) begin errors++; $display("FAIL fill_readback got %h expected %h", a_z, {64'd21, 64'd6}); end
    da = 5'd2;
    d = 64'd99;
    w = 1'b1;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    w = 1'b0;
    n = 0;
    drop_trace = '0;
    while (busy_z && n < 100) begin
      #1;
      if (n < 8) drop_trace[n] = wr_drop_z;
      w = (n == 5);
      da = 5'd4;
      d = 64'd55;
      n++;
      tick();
    end
    w = 1'b0;
    checks++; if (n !== 32) begin errors++; $display("FAIL clear_busy_cycles got %0d expected 32", n); end
    checks++; if (drop_trace !== 8'b0100_0001) begin errors++; $display("FAIL wr_drop_trace got %b expected 01000001", drop_trace); end
    // first idle cycle: write must be accepted
    da = 5'd6;
    d = 64'h1234;
    w = 1'b1;
    tick();
    w = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      sa = {5'(i), 5'(i)};
      #1;
      if (i == 6) begin
        if (a_z !== {64'h1234, 64'h1234}) bad++;
      end else if (a_z !== 128'h0) begin
        bad++;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL post_clear_regs got %0d wrong expected 0", bad); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (busy_z !== 1'b1) begin errors++; $display("FAIL mid_sweep_busy got %b expected 1", busy_z); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n = 0;
    while (busy_z && n < 100) begin
      n++;
      tick();
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL restart_busy_cycles got %0d expected 32", n); end
  endtask

  task automatic test_small();
    int n;
    n = 0;
    while (s_busy && n < 100) begin
      n++;
      tick();
    end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL small_idle got %b expected 0", s_busy); end
    for (int i = 0; i < 8; i++) begin
      s_da = 3'(i);
      s_d = 16'h1000 + 16'(i);
      s_w = 1'b1;
      tick();
    end
    s_w = 1'b0;
    s_sa = {3'd7, 3'd3, 3'd3, 3'd0};
    s_dbg_sel = 3'd3;
    #1;
    checks++; if (s_a !== {16'h0, 16'h1003, 16'h1003, 16'h1000}) begin errors++; $display("FAIL small_reads got %h expected 0000100310031000", s_a); end
    checks++; if (s_dbg !== 16'h1003) begin errors++; $display("FAIL small_dbg got %h expected 1003", s_dbg); end
    checks++; if (s_wr_drop !== 1'b0) begin errors++; $display("FAIL small_wr_drop got %b expected 0", s_wr_drop); end
    s_dbg_sel = 3'd7;
    #1;
    checks++; if (s_dbg !== 16'h0) begin errors++; $display("FAIL small_dbg_zero_reg got %h expected 0000", s_dbg); end
  endtask

  initial begin
    reset = 1'b0;
    sa = '0; d = '0; da = '0; w = 1'b0; clr_req = 1'b0; dbg_sel = '0;
    s_sa = '0; s_d = '0; s_da = '0; s_w = 1'b0; s_clr = 1'b0; s_dbg_sel = '0;
    test_reset();
    test_write_forward();
    test_zero_reg();
    test_clear_collision();
    test_reset_mid_sweep();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
